// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg: shared defaults and types for the instruction memory slice.
//   DATA_W_DEF / ADDR_W_DEF / DEPTH_DEF : default geometry (32-bit words, 2048 deep)
//   HALT_WORD_DEF : encoding of the halt instruction
//   NOP_WORD      : bubble value driven on flush / out-of-range fetch
//   state_e       : fetch FSM states (INIT clears the array, RUN serves fetches)
package prog_mem_pkg;

    localparam int          DATA_W_DEF    = 32;
    localparam int          ADDR_W_DEF    = 11;
    localparam int          DEPTH_DEF     = 2048;
    localparam logic [31:0] HALT_WORD_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/prog_mem_ram.sv
// prog_mem_ram: one write port, one registered read port, write-first on collision.
//   clock_i           : rising-edge clock
//   we_i/waddr_i/wdata_i : write strobe, address, data
//   re_i/raddr_i      : read enable and address; rdata_o updates only when re_i=1
//   rdata_o           : registered read data (holds while re_i=0)
// The array and read register carry no reset so the tools can map them onto block RAM.
module prog_mem_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic          clock_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            // Same-address write in this cycle is forwarded so the reader sees new data.
            if (we_i && (waddr_i == raddr_i)) begin
                rdata_q <= wdata_i;
            end else begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_mem_fetch.sv
// prog_mem_fetch: IF-stage instruction memory with self-clear, program-load port,
// stall/flush handshake and sticky halt detection.
//   clock, reset_n                 : clock, asynchronous active-low reset
//   fetch_req, addr, stall, flush  : fetch request and hazard-unit controls
//   inst, inst_valid               : fetch result, one cycle after the request
//   load_en, load_addr, load_data  : program-load write port (RUN only)
//   ready                          : array cleared, fetches and loads accepted
//   halted                         : sticky, HALT_WORD delivered with inst_valid=1
//   parity_err                     : stored parity mismatch on current inst
// Optional feature macro: PROG_MEM_PARITY_EN adds an even-parity bit per word;
// without it parity_err is tied low.
module prog_mem_fetch
    import prog_mem_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DEPTH     = DEPTH_DEF,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEF)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              ready,
    output logic              halted,
    output logic              parity_err
);

`ifdef PROG_MEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int RAM_W = DATA_W + PAR_W;

    state_e            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              ready_q;
    logic              inst_valid_q;
    // When set, inst reads as the bubble word instead of the RAM read register.
    logic              inst_zero_q;
    logic              halted_q;

    logic              run;
    logic              load_ok;
    logic              fetch_ok;
    logic              ram_we_d;
    logic [ADDR_W-1:0] ram_waddr_d;
    logic [RAM_W-1:0]  ram_wdata_d;
    logic              ram_re_d;
    logic [RAM_W-1:0]  load_word;
    logic [RAM_W-1:0]  ram_rdata;
    logic              halt_hit;
    logic              halted_d;

`ifdef PROG_MEM_PARITY_EN
    assign load_word = {^load_data, load_data};
`else
    assign load_word = load_data;
`endif

    always_comb begin
        run         = (state_q == RUN);
        load_ok     = (32'(load_addr) < 32'(DEPTH));
        fetch_ok    = (32'(addr) < 32'(DEPTH));
        // INIT owns the write port to clear the array; loads are dropped meanwhile.
        ram_we_d    = run ? (load_en && load_ok) : 1'b1;
        ram_waddr_d = run ? load_addr : clr_cnt_q;
        ram_wdata_d = run ? load_word : '0;
        ram_re_d    = run && !flush && !stall && fetch_req && fetch_ok;
    end

    prog_mem_ram #(
        .W     (RAM_W),
        .DEPTH (DEPTH),
        .AW    (ADDR_W)
    ) u_ram (
        .clock_i (clock),
        .we_i    (ram_we_d),
        .waddr_i (ram_waddr_d),
        .wdata_i (ram_wdata_d),
        .re_i    (ram_re_d),
        .raddr_i (addr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= INIT;
            clr_cnt_q    <= '0;
            ready_q      <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_zero_q  <= 1'b1;
            halted_q     <= 1'b0;
        end else begin
            halted_q <= halted_d;
            case (state_q)
                INIT: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (flush) begin
                        inst_valid_q <= 1'b0;
                        inst_zero_q  <= 1'b1;
                    end else if (stall) begin
                        inst_valid_q <= inst_valid_q;
                    end else if (fetch_req) begin
                        inst_valid_q <= 1'b1;
                        inst_zero_q  <= !fetch_ok;
                    end else begin
                        inst_valid_q <= 1'b0;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign inst       = inst_zero_q ? DATA_W'(NOP_WORD) : ram_rdata[DATA_W-1:0];
    assign inst_valid = inst_valid_q;
    assign ready      = ready_q;

    // The fetched word only exists after the read edge, so the halt match is taken
    // on the current output and folded into the sticky register.
    assign halt_hit = inst_valid_q && (inst == HALT_WORD);
    assign halted_d = halted_q || halt_hit;
    assign halted   = halted_d;

`ifdef PROG_MEM_PARITY_EN
    assign parity_err = inst_valid_q && !inst_zero_q &&
                        (ram_rdata[DATA_W] != ^ram_rdata[DATA_W-1:0]);
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mem_fetch.sv
module tb_prog_mem_fetch;

    logic        clock;
    logic        reset_n;
    logic        fetch_req;
    logic [10:0] addr;
    logic        stall;
    logic        flush;
    logic [31:0] inst;
    logic        inst_valid;
    logic        load_en;
    logic [10:0] load_addr;
    logic [31:0] load_data;
    logic        ready;
    logic        halted;
    logic        parity_err;

    int checks_cnt = 0;
    int errors_cnt = 0;

    prog_mem_fetch dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .fetch_req  (fetch_req),
        .addr       (addr),
        .stall      (stall),
        .flush      (flush),
        .inst       (inst),
        .inst_valid (inst_valid),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .ready      (ready),
        .halted     (halted),
        .parity_err (parity_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_req = 1'b0;
        addr      = '0;
        stall     = 1'b0;
        flush     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
    endtask

    task automatic noise();
        load_en   = 1'b1;
        load_addr = 11'd9;
        load_data = 32'hAAAA_5555;
        fetch_req = 1'b1;
        addr      = 11'd9;
    endtask

    // Counts edges until ready rises; optionally hammers fetch/load meanwhile.
    task automatic wait_ready(input string tag, input logic do_noise);
        int cnt;
        int seen_valid;
        cnt = 0;
        seen_valid = 0;
        for (int i = 0; i < 4000; i++) begin
            if (do_noise) noise();
            step();
            cnt++;
            if (inst_valid) seen_valid++;
            if (ready) break;
        end
        idle_inputs();
        chk({tag, "_init_len"}, 32'(cnt), 32'd2048);
        chk({tag, "_init_quiet"}, 32'(seen_valid), 32'd0);
    endtask

    task automatic do_reset(input string tag, input logic do_noise);
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        wait_ready(tag, do_noise);
    endtask

    task automatic load(input logic [10:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_parity", 32'(parity_err), 32'd0);

        // 1: clear length, cleared word is the halt encoding
        do_reset("t1", 1'b0);
        fetch_req = 1'b1; addr = 11'd5;
        step();
        fetch_req = 1'b0;
        chk("t1_inst", inst, 32'h0);
        chk("t1_valid", 32'(inst_valid), 32'd1);
        chk("t1_halted", 32'(halted), 32'd1);
        step();
        chk("t1_valid_drop", 32'(inst_valid), 32'd0);
        chk("t1_halted_sticky", 32'(halted), 32'd1);

        // 2: load then back-to-back fetch
        do_reset("t2", 1'b0);
        load(11'd0, 32'h0000_0C01);
        load(11'd1, 32'h0000_0801);
        fetch_req = 1'b1; addr = 11'd0;
        step();
        chk("t2_inst0", inst, 32'h0000_0C01);
        chk("t2_valid0", 32'(inst_valid), 32'd1);
        addr = 11'd1;
        step();
        fetch_req = 1'b0;
        chk("t2_inst1", inst, 32'h0000_0801);
        chk("t2_valid1", 32'(inst_valid), 32'd1);
        chk("t2_halted", 32'(halted), 32'd0);
        step();
        chk("t2_idle_inst_hold", inst, 32'h0000_0801);
        chk("t2_idle_valid", 32'(inst_valid), 32'd0);

        // 3: stall holds, flush wins over stall
        fetch_req = 1'b1; addr = 11'd1;
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr = (i == 0) ? 11'd0 : 11'(i + 1);
            step();
            chk($sformatf("t3_stall_inst%0d", i), inst, 32'h0000_0801);
            chk($sformatf("t3_stall_valid%0d", i), 32'(inst_valid), 32'd1);
        end
        flush = 1'b1;
        step();
        flush = 1'b0; stall = 1'b0; fetch_req = 1'b0;
        chk("t3_flush_inst", inst, 32'h0);
        chk("t3_flush_valid", 32'(inst_valid), 32'd0);
        chk("t3_flush_halted", 32'(halted), 32'd0);

        // 4: write-first collisions, including the top word
        load_en = 1'b1; load_addr = 11'd7; load_data = 32'hDEAD_BEEF;
        fetch_req = 1'b1; addr = 11'd7;
        step();
        chk("t4_wf7", inst, 32'hDEAD_BEEF);
        load_addr = 11'd2047; load_data = 32'h1234_5678; addr = 11'd2047;
        step();
        chk("t4_wf2047", inst, 32'h1234_5678);
        load_en = 1'b0; addr = 11'd7;
        step();
        chk("t4_rd7", inst, 32'hDEAD_BEEF);
        addr = 11'd2047;
        step();
        fetch_req = 1'b0;
        chk("t4_rd2047", inst, 32'h1234_5678);
        chk("t4_parity", 32'(parity_err), 32'd0);
        chk("t4_halted", 32'(halted), 32'd0);

        // 5: asynchronous reset mid-RUN and mid-INIT; loads during INIT dropped
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_run_rst_ready", 32'(ready), 32'd0);
        chk("t5_run_rst_inst", inst, 32'h0);
        chk("t5_run_rst_valid", 32'(inst_valid), 32'd0);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            noise();
            step();
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_init_rst_ready", 32'(ready), 32'd0);
        chk("t5_init_rst_valid", 32'(inst_valid), 32'd0);
        #2;
        reset_n = 1'b1;
        wait_ready("t5", 1'b1);
        fetch_req = 1'b1; addr = 11'd9;
        step();
        chk("t5_rd9", inst, 32'h0);
        chk("t5_valid9", 32'(inst_valid), 32'd1);
        addr = 11'd7;
        step();
        fetch_req = 1'b0;
        chk("t5_rd7_cleared", inst, 32'h0);

        // 6: parity
        load(11'd3, 32'h0000_0001);
`ifdef PROG_MEM_PARITY_EN
        dut.u_ram.mem_q[3][4] = ~dut.u_ram.mem_q[3][4];
        fetch_req = 1'b1; addr = 11'd3;
        step();
        fetch_req = 1'b0;
        chk("t6_inst", inst, 32'h0000_0011);
        chk("t6_valid", 32'(inst_valid), 32'd1);
        chk("t6_parity", 32'(parity_err), 32'd1);
`else
        fetch_req = 1'b1; addr = 11'd3;
        step();
        fetch_req = 1'b0;
        chk("t6_inst", inst, 32'h0000_0001);
        chk("t6_valid", 32'(inst_valid), 32'd1);
        chk("t6_parity", 32'(parity_err), 32'd0);
`endif
        step();
        chk("t6_parity_idle", 32'(parity_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule
